// File: rtl/leitor_load_aste_pkg.sv
// Shared definitions for the asteroid load table reader and the load memory
// that feeds it: default geometry, the empty-entry code and the FSM states.
package leitor_load_aste_pkg;

    // Load memory geometry shared with the setup-side writer
    localparam int DEF_N_SLOTS = 16;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 2;

    // Entry code meaning "no asteroid in this slot"
    localparam logic [DEF_DATA_W-1:0] TIPO_VAZIO = 2'b00;

    // Reader states; LIMPA is only reachable when the clear-after-read build is selected
    typedef enum logic [2:0] {
        IDLE,
        ESPERA,
        LE,
        OFERTA,
        LIMPA,
        FIM
    } estado_t;

endpackage

// File: rtl/leitor_load_aste.sv
// Sequential reader of the asteroid load memory. On a start pulse it walks
// every slot, waits out the RAM's one-cycle read latency and offers each
// non-empty entry to the spawner over a valid/ready handshake.
// Build option: define LIMPA_APOS_LER_EN to erase each slot right after its
// entry has been accepted, so a later scan no longer sees consumed asteroids.
module leitor_load_aste
    import leitor_load_aste_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [ADDR_W-1:0] spawn_slot,
    output logic [DATA_W-1:0] spawn_tipo,
    output logic              ocupado,
    output logic              pronto,
    output logic [ADDR_W:0]   qtd_spawn
);

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_SLOTS - 1);

    estado_t r_estado;
    estado_t w_prox;

    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_tipo;
    logic [ADDR_W:0]   r_qtd;

    logic w_vazio;
    logic w_aceite;
    logic w_ultimo;
    logic w_avanca;

    assign w_vazio  = (mem_q == DATA_W'(TIPO_VAZIO));
    assign w_aceite = (r_estado == OFERTA) && spawn_ready;
    assign w_ultimo = (r_idx == ULTIMO);

`ifdef LIMPA_APOS_LER_EN
    assign w_avanca = ((r_estado == LE) && w_vazio) || (r_estado == LIMPA);
`else
    assign w_avanca = ((r_estado == LE) && w_vazio) || w_aceite;
`endif

    assign qtd_spawn = r_qtd;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state selection; an empty slot or a finished slot moves on to the next address
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            IDLE: begin
                if (iniciar) begin
                    w_prox = ESPERA;
                end
            end
            ESPERA: begin
                w_prox = LE;
            end
            LE: begin
                if (!w_vazio) begin
                    w_prox = OFERTA;
                end else if (w_ultimo) begin
                    w_prox = FIM;
                end else begin
                    w_prox = ESPERA;
                end
            end
            OFERTA: begin
                if (spawn_ready) begin
`ifdef LIMPA_APOS_LER_EN
                    w_prox = LIMPA;
`else
                    w_prox = w_ultimo ? FIM : ESPERA;
`endif
                end
            end
`ifdef LIMPA_APOS_LER_EN
            LIMPA: begin
                w_prox = w_ultimo ? FIM : ESPERA;
            end
`endif
            FIM: begin
                w_prox = IDLE;
            end
            default: begin
                w_prox = IDLE;
            end
        endcase
    end

    // Slot index, captured entry and accepted-spawn count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_tipo <= '0;
            r_qtd  <= '0;
        end else begin
            if ((r_estado == IDLE) && iniciar) begin
                r_idx <= '0;
                r_qtd <= '0;
            end else if (r_estado == FIM) begin
                r_idx <= '0;
            end else if (w_avanca && !w_ultimo) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_estado == LE) begin
                r_tipo <= mem_q;
            end

            if (w_aceite) begin
                r_qtd <= r_qtd + 1'b1;
            end
        end
    end

    // Output decode; the memory address always follows the slot index
    always_comb begin
        mem_addr    = r_idx;
        mem_data    = DATA_W'(TIPO_VAZIO);
        mem_we      = 1'b0;
        spawn_valid = 1'b0;
        spawn_slot  = '0;
        spawn_tipo  = '0;
        ocupado     = (r_estado != IDLE);
        pronto      = 1'b0;
        case (r_estado)
            OFERTA: begin
                spawn_valid = 1'b1;
                spawn_slot  = r_idx;
                spawn_tipo  = r_tipo;
            end
`ifdef LIMPA_APOS_LER_EN
            LIMPA: begin
                mem_we = 1'b1;
            end
`endif
            FIM: begin
                pronto = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_leitor_load_aste.sv
// Self-checking bench for leitor_load_aste. A registered-address RAM model
// stands in for the load memory; expected spawns are queued from a shadow
// copy of the memory image when a scan starts and popped as transfers occur.
// Honours LIMPA_APOS_LER_EN when the same macro is defined for the bench.
module tb_leitor_load_aste;
    import leitor_load_aste_pkg::*;

    localparam int NS = DEF_N_SLOTS;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

`ifdef LIMPA_APOS_LER_EN
    localparam int LIMPA_CYC = 1;
`else
    localparam int LIMPA_CYC = 0;
`endif

    typedef struct packed {
        logic [AW-1:0] slot;
        logic [DW-1:0] tipo;
    } spawnExp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic          spawn_valid;
    logic          spawn_ready;
    logic [AW-1:0] spawn_slot;
    logic [DW-1:0] spawn_tipo;
    logic          ocupado;
    logic          pronto;
    logic [AW:0]   qtd_spawn;

    logic [DW-1:0] ram [NS];
    logic [AW-1:0] ramAddr;
    logic          tbWe;
    logic [AW-1:0] tbAddr;
    logic [DW-1:0] tbData;

    logic [DW-1:0] shadow [NS];
    spawnExp_t     sbQueue [$];

    int cyc = 0;
    int startCyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to time events relative to a start pulse
    always @(posedge clk) cyc <= cyc + 1;

    // Load memory model: synchronous write, registered read address
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end else if (tbWe) begin
            ram[tbAddr] <= tbData;
        end
        ramAddr <= mem_addr;
    end
    assign mem_q = ram[ramAddr];

    leitor_load_aste dut (
        .clk         (clk),
        .reset       (reset),
        .iniciar     (iniciar),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_data    (mem_data),
        .mem_q       (mem_q),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_slot  (spawn_slot),
        .spawn_tipo  (spawn_tipo),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .qtd_spawn   (qtd_spawn)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Optionally loads a memory image, queues the expected spawns and pulses iniciar
    task automatic applyStimulus(input logic [2*NS-1:0] image, input bit reload, output int nSpawn);
        spawnExp_t e;
        nSpawn = 0;
        if (reload) begin
            for (int s = 0; s < NS; s++) begin
                @(posedge clk);
                #1;
                tbWe      = 1'b1;
                tbAddr    = AW'(s);
                tbData    = image[2*s +: 2];
                shadow[s] = image[2*s +: 2];
            end
            @(posedge clk);
            #1 tbWe = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            if (shadow[s] != '0) begin
                e.slot = AW'(s);
                e.tipo = shadow[s];
                sbQueue.push_back(e);
                nSpawn++;
            end
        end
        @(posedge clk);
        #1 iniciar = 1'b1;
        startCyc = cyc;
        @(posedge clk);
        #1 iniciar = 1'b0;
    endtask

    // Follows a scan on falling edges: drives ready, scores offers, watches writes and pronto
    task automatic runScan(input int budget, input bit holdReady, input int abortSlot, input int repulseAt,
                           output int prontoAt, output int xfers, output int waits, output int weCount,
                           output int firstXfer, output bit aborted);
        int n = 0;
        int waitCnt = 0;
        int lastSlot = 0;
        bit done = 1'b0;
        spawnExp_t e;
        prontoAt = -1; xfers = 0; waits = 0; weCount = 0; firstXfer = -1; aborted = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (n == repulseAt) iniciar = 1'b1;
            else if (n == repulseAt + 1) iniciar = 1'b0;
            if (holdReady) begin
                if (!spawn_valid) begin
                    waitCnt = 0;
                    spawn_ready = 1'b0;
                end else if (waitCnt < 5) begin
                    waitCnt++;
                    spawn_ready = 1'b0;
                end else begin
                    spawn_ready = 1'b1;
                end
            end else begin
                spawn_ready = 1'b1;
            end
            if (spawn_valid) begin
                if (abortSlot >= 0 && spawn_slot == AW'(abortSlot) && waitCnt >= 2) begin
                    aborted = 1'b1;
                    done = 1'b1;
                end else if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_spawn", {31'd0, spawn_valid}, 32'd0);
                end else begin
                    e = sbQueue[0];
                    checkOutput("spawn_slot", spawn_slot, e.slot);
                    checkOutput("spawn_tipo", spawn_tipo, e.tipo);
                    if (spawn_ready) begin
                        void'(sbQueue.pop_front());
                        xfers++;
                        lastSlot = e.slot;
                        if (firstXfer < 0) firstXfer = cyc - startCyc;
                        if (LIMPA_CYC == 1) shadow[e.slot] = '0;
                    end else begin
                        waits++;
                    end
                end
            end
            if (mem_we) begin
                weCount++;
                checkOutput("we_addr", mem_addr, lastSlot);
                checkOutput("we_data", mem_data, 32'd0);
            end
            if (pronto) begin
                prontoAt = cyc - startCyc;
                done = 1'b1;
            end
        end
        if (!done) checkOutput("scan_timeout", {31'd0, done}, 32'd1);
    endtask

    // One complete scan with timing, count and idle-after-pronto checks
    task automatic scanTest(input string name, input logic [31:0] image, input bit reload,
                            input bit holdReady, input int repulseAt, input int expFirst);
        int nSpawn, prontoAt, xfers, waits, weCount, firstXfer;
        int expWaits;
        bit aborted;
        applyStimulus(image, reload, nSpawn);
        runScan(300, holdReady, -1, repulseAt, prontoAt, xfers, waits, weCount, firstXfer, aborted);
        expWaits = holdReady ? 5 * nSpawn : 0;
        checkOutput({name, "_pronto_cyc"}, prontoAt, 1 + 2*NS + nSpawn*(1 + LIMPA_CYC) + expWaits);
        checkOutput({name, "_qtd"}, qtd_spawn, nSpawn);
        checkOutput({name, "_xfers"}, xfers, nSpawn);
        checkOutput({name, "_waits"}, waits, expWaits);
        checkOutput({name, "_we_count"}, weCount, nSpawn * LIMPA_CYC);
        checkOutput({name, "_sb_left"}, sbQueue.size(), 32'd0);
        if (expFirst >= 0) checkOutput({name, "_first_xfer"}, firstXfer, expFirst);
        @(negedge clk);
        checkOutput({name, "_ocupado_after"}, {31'd0, ocupado}, 32'd0);
        checkOutput({name, "_pronto_pulse"}, {31'd0, pronto}, 32'd0);
    endtask

    // Test sequence
    initial begin
        int nSp, prontoAt, xfers, waits, weCount, firstXfer, busyCnt;
        bit aborted;

        reset = 1'b1; iniciar = 1'b0; spawn_ready = 1'b0;
        tbWe = 1'b0; tbAddr = '0; tbData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, spawn_valid}, 32'd0);
        checkOutput("rst_ocupado", {31'd0, ocupado}, 32'd0);
        checkOutput("rst_pronto", {31'd0, pronto}, 32'd0);
        checkOutput("rst_qtd", qtd_spawn, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] default image, ready high");
        scanTest("dflt", 32'h0000_0002, 1'b1, 1'b0, -1, 3);

        $display("[TB] slots 3/7/15 with ready held low");
        scanTest("hold", 32'h8000_C040, 1'b1, 1'b1, -1, -1);

        $display("[TB] empty memory");
        scanTest("empty", 32'h0000_0000, 1'b1, 1'b0, -1, -1);

        $display("[TB] iniciar re-pulsed mid-scan");
        scanTest("repulse", 32'h0000_0002, 1'b1, 1'b0, 10, 3);
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pronto || ocupado || spawn_valid) busyCnt++;
        end
        checkOutput("repulse_idle", busyCnt, 32'd0);

        $display("[TB] reset during offer of slot 7");
        applyStimulus(32'h0000_C040, 1'b1, nSp);
        runScan(300, 1'b1, 7, -1, prontoAt, xfers, waits, weCount, firstXfer, aborted);
        checkOutput("abort_reached", {31'd0, aborted}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, spawn_valid}, 32'd0);
        checkOutput("arst_slot", spawn_slot, 32'd0);
        checkOutput("arst_tipo", spawn_tipo, 32'd0);
        checkOutput("arst_ocupado", {31'd0, ocupado}, 32'd0);
        checkOutput("arst_qtd", qtd_spawn, 32'd0);
        checkOutput("arst_addr", mem_addr, 32'd0);
        sbQueue.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        scanTest("after_rst", 32'h0000_C040, 1'b1, 1'b0, -1, -1);

        $display("[TB] rescan without reloading memory");
        scanTest("first", 32'h0000_0002, 1'b1, 1'b0, -1, 3);
        scanTest("rescan", 32'h0000_0000, 1'b0, 1'b0, -1, -1);
        checkOutput("rescan_qtd_fixed", qtd_spawn, (LIMPA_CYC == 1) ? 32'd0 : 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
